inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction-fetch controller between the program counter and the instruction memory. Each cycle it drives the word address of the current fetch PC into the combinational instruction memory, captures the returned word with its PC in a small fetch buffer, and presents instructions to decode over a valid/ready handshake. It also handles control-flow redirects by flushing and restarting, and halts with a fault on out-of-range or misaligned fetch targets.

## Interface
- RESET_PC, 32'h0000_0000: byte PC fetched first after reset.
- MEM_WORDS, 64: instruction memory depth in 32-bit words; valid word indices are 0..MEM_WORDS-1.
- DEPTH, 2: fetch buffer entries (≥2, power of two).

- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- o_mem_addr  output  32  word address to instruction memory = fetch_pc >> 2.
- i_mem_data  input  32  instruction word, combinationally valid in the same cycle as o_mem_addr.
- o_inst_valid  output  1  buffer head holds a valid instruction.
- i_inst_ready  input  1  decode accepts the head this cycle.
- o_inst  output  32  head instruction word.
- o_pc  output  32  head instruction byte PC.
- i_redirect  input  1  flush and restart fetch at i_redirect_pc.
- i_redirect_pc  input  32  redirect target byte PC.
- o_fault  output  1  fetch halted on a bad target.
- o_fault_pc  output  32  PC that caused the fault.

## Operation
- State: RUN and FAULT. Registers: fetch_pc, FIFO of DEPTH {pc, inst} entries, occupancy count.
- Fetch (RUN, no redirect): if the FIFO is not full, or will pop this cycle, and fetch_pc[31:2] < MEM_WORDS, then push {fetch_pc, i_mem_data} and set fetch_pc += 4 (mod 2^32). If full and not popping, hold fetch_pc with no push.
- Out-of-range fetch in RUN: no push. State goes to FAULT, o_fault = 1, o_fault_pc = fetch_pc. Entries already buffered still drain normally.
- Pop: when o_inst_valid && i_inst_ready, the head is removed. Push and pop in the same cycle leave the count unchanged, including at full.
- Redirect has priority over everything. It clears the FIFO (a same-cycle pop is discarded, no push) and sets fetch_pc = i_redirect_pc.
  - If i_redirect_pc[1:0] != 0 or i_redirect_pc[31:2] >= MEM_WORDS: state becomes FAULT and o_fault_pc = i_redirect_pc.
  - Otherwise: state becomes RUN and o_fault clears.
- FAULT: no fetches. Leave only by a valid redirect or by reset.
- o_mem_addr is driven as fetch_pc >> 2 in every state. The memory read is side-effect free.

## Timing
- Reset values: state RUN, fetch_pc = RESET_PC, FIFO empty, o_inst_valid = 0, o_inst = 0, o_pc = 0, o_fault = 0, o_fault_pc = 0, o_mem_addr = RESET_PC >> 2.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously). Any in-flight fetch is lost.
- Fetch latency: a word fetched in cycle N is at the head, with o_inst_valid = 1, in cycle N+1 if the FIFO was empty. First valid instruction appears in the first cycle after the first rising edge following reset release.
- Redirect in cycle N:
  - o_inst_valid = 0 in cycle N+1.
  - The target word is fetched in cycle N+1 and is valid in N+2.
  - Redirect penalty is 2 cycles.
- Steady state with i_inst_ready held at 1: one instruction per cycle, no bubbles.
- o_fault rises the cycle after the faulting fetch or redirect edge.
- o_inst and o_pc are registered FIFO outputs. There is no combinational path from i_mem_data to o_inst.

## Structure
- Shared package fetch_pkg holds:
  - the state enum {RUN, FAULT};
  - the fetch-entry struct {pc[31:0], inst[31:0]};
  - the constant INST_BYTES = 4.
- Sub-module fetch_fifo is a synchronous FIFO with parameterised DEPTH and entry width, with push/pop/full/empty ports and simultaneous push+pop support. The controller holds the FSM, PC and range checks.

## Test plan
- Reset release with RESET_PC=0, memory[0]=32'h00A00593, memory[1]=32'h00058073, i_inst_ready=1 -> cycle 1: o_pc=0, o_inst=32'h00A00593; cycle 2: o_pc=4, o_inst=32'h00058073; cycle 3: o_pc=8, o_inst=0.
- Hold i_inst_ready=0 for 5 cycles -> exactly DEPTH entries buffered (PCs 0 and 4), fetch_pc holds at 8. Release -> PCs 0, 4, 8 delivered with no gap or duplicate.
- Redirect to 32'h10 while the FIFO holds 2 entries and i_inst_ready=1 -> both entries dropped; next valid o_pc=32'h10, 2 cycles after the redirect.
- Free-run to PC = 4*MEM_WORDS-4 -> last word delivered; next cycle o_fault=1, o_fault_pc=4*MEM_WORDS; no further valid output. Then redirect to 0 -> o_fault=0, o_pc=0 resumes.
- Redirect to 32'h6 -> o_fault=1, o_fault_pc=32'h6, FIFO empty, o_inst_valid stays 0.
- Assert i_rst_n low for half a cycle mid-stream with the FIFO full -> o_inst_valid=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller and its fetch buffer.
package fetch_pkg;

    localparam int INST_BYTES = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, simultaneous push/pop (also at full) and a zeroed head when empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the empty flag masks stale contents on o_data.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, range/alignment checks, redirect flush, fault FSM.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64,
    parameter int          DEPTH     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fault,
    output logic [31:0] o_fault_pc
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0]  r_fault_pc, w_fault_pc_nxt;
    logic         w_push;
    logic         w_pop;
    logic         w_flush;
    logic         w_full;
    logic         w_empty;
    logic         w_in_range;
    logic         w_redirect_bad;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_in_range     = (r_fetch_pc[31:2] < 30'(MEM_WORDS));
    assign w_redirect_bad = (i_redirect_pc[1:0] != 2'b00) ||
                            (i_redirect_pc[31:2] >= 30'(MEM_WORDS));
    assign w_pop          = o_inst_valid && i_inst_ready;
    assign w_push_entry   = '{pc: r_fetch_pc, inst: i_mem_data};

    assign o_mem_addr   = {2'b00, r_fetch_pc[31:2]};
    assign o_inst_valid = !w_empty;
    assign o_inst       = w_head.inst;
    assign o_pc         = w_head.pc;
    assign o_fault      = (r_state == FAULT);
    assign o_fault_pc   = r_fault_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RUN;
            r_fetch_pc <= RESET_PC;
            r_fault_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_fault_pc <= w_fault_pc_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_fault_pc_nxt = r_fault_pc;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        if (i_redirect) begin
            w_flush        = 1'b1;
            w_fetch_pc_nxt = i_redirect_pc;
            if (w_redirect_bad) begin
                w_state_nxt    = FAULT;
                w_fault_pc_nxt = i_redirect_pc;
            end else begin
                w_state_nxt = RUN;
            end
        end else if (r_state == RUN) begin
            if (!w_in_range) begin
                w_state_nxt    = FAULT;
                w_fault_pc_nxt = r_fetch_pc;
            end else if (!w_full || w_pop) begin
                w_push         = 1'b1;
                w_fetch_pc_nxt = r_fetch_pc + 32'(INST_BYTES);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a combinational 64-word instruction memory.
module tb_inst_fetch_ctrl;

    localparam int MEM_WORDS = 64;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] o_mem_addr;
    logic [31:0] i_mem_data;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_fault;
    logic [31:0] o_fault_pc;

    logic [31:0] tb_mem [MEM_WORDS];
    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    assign i_mem_data = (o_mem_addr < 32'(MEM_WORDS)) ? tb_mem[o_mem_addr[5:0]] : 32'hDEAD_BEEF;

    inst_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (MEM_WORDS),
        .DEPTH     (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_mem_addr    (o_mem_addr),
        .i_mem_data    (i_mem_data),
        .o_inst_valid  (o_inst_valid),
        .i_inst_ready  (i_inst_ready),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fault       (o_fault),
        .o_fault_pc    (o_fault_pc)
    );

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        case (w)
            32'd0:   return 32'h00A0_0593;
            32'd1:   return 32'h0005_8073;
            32'd2:   return 32'h0000_0000;
            default: return 32'h1000_0000 + w;
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset(input logic ready);
        i_rst_n      = 1'b0;
        i_redirect   = 1'b0;
        i_inst_ready = ready;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_inst_valid, o_inst, o_pc, o_fault, o_fault_pc, o_mem_addr} !==
            {1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b inst=%h pc=%h f=%b fpc=%h addr=%h, required all zero",
                     o_inst_valid, o_inst, o_pc, o_fault, o_fault_pc, o_mem_addr);
        end
    endtask

    task automatic test_first_fetch();
        do_reset(1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({o_inst_valid, o_pc, o_inst} !== {1'b1, 32'(c * 4), exp_inst(32'(c * 4))}) begin
                errors++;
                $display("FAIL first_fetch[%0d]: got v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h",
                         c, o_inst_valid, o_pc, o_inst, 32'(c * 4), exp_inst(32'(c * 4)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        repeat (5) tick();
        checks++;
        if ({o_inst_valid, o_pc, o_inst, o_mem_addr} !== {1'b1, 32'h0, 32'h00A0_0593, 32'd2}) begin
            errors++;
            $display("FAIL backpressure_hold: got v=%b pc=%h inst=%h addr=%h, required v=1 pc=0 inst=00a00593 addr=2",
                     o_inst_valid, o_pc, o_inst, o_mem_addr);
        end
        i_inst_ready = 1'b1;
        for (int c = 1; c < 4; c++) begin
            tick();
            checks++;
            if ({o_inst_valid, o_pc, o_inst} !== {1'b1, 32'(c * 4), exp_inst(32'(c * 4))}) begin
                errors++;
                $display("FAIL backpressure_drain[%0d]: got v=%b pc=%h inst=%h, required v=1 pc=%h",
                         c, o_inst_valid, o_pc, o_inst, 32'(c * 4));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (3) tick();
        i_inst_ready  = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h10;
        tick();
        i_redirect = 1'b0;
        checks++;
        if ({o_inst_valid, o_mem_addr, o_fault} !== {1'b0, 32'd4, 1'b0}) begin
            errors++;
            $display("FAIL redirect_bubble: got v=%b addr=%h f=%b, required v=0 addr=4 f=0",
                     o_inst_valid, o_mem_addr, o_fault);
        end
        for (int p = 32'h10; p <= 32'h14; p += 4) begin
            tick();
            checks++;
            if ({o_inst_valid, o_pc, o_inst} !== {1'b1, 32'(p), exp_inst(32'(p))}) begin
                errors++;
                $display("FAIL redirect_target: got v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h",
                         o_inst_valid, o_pc, o_inst, 32'(p), exp_inst(32'(p)));
            end
        end
    endtask

    task automatic test_fault_range();
        for (int p = 32'h18; p <= 4 * MEM_WORDS - 4; p += 4) begin
            tick();
            checks++;
            if ({o_inst_valid, o_pc, o_inst, o_fault} !== {1'b1, 32'(p), exp_inst(32'(p)), 1'b0}) begin
                errors++;
                $display("FAIL freerun: got v=%b pc=%h inst=%h f=%b, required v=1 pc=%h f=0",
                         o_inst_valid, o_pc, o_inst, o_fault, 32'(p));
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({o_inst_valid, o_fault, o_fault_pc, o_mem_addr} !==
                {1'b0, 1'b1, 32'(4 * MEM_WORDS), 32'(MEM_WORDS)}) begin
                errors++;
                $display("FAIL range_fault[%0d]: got v=%b f=%b fpc=%h addr=%h, required v=0 f=1 fpc=%h addr=%h",
                         c, o_inst_valid, o_fault, o_fault_pc, o_mem_addr,
                         32'(4 * MEM_WORDS), 32'(MEM_WORDS));
            end
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0;
        tick();
        i_redirect = 1'b0;
        checks++;
        if ({o_inst_valid, o_fault} !== 2'b00) begin
            errors++;
            $display("FAIL fault_clear: got v=%b f=%b, required v=0 f=0", o_inst_valid, o_fault);
        end
        tick();
        checks++;
        if ({o_inst_valid, o_pc, o_inst} !== {1'b1, 32'h0, 32'h00A0_0593}) begin
            errors++;
            $display("FAIL fault_resume: got v=%b pc=%h inst=%h, required v=1 pc=0 inst=00a00593",
                     o_inst_valid, o_pc, o_inst);
        end
    endtask

    task automatic test_bad_redirect(input logic [31:0] target);
        i_redirect    = 1'b1;
        i_redirect_pc = target;
        tick();
        i_redirect = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({o_inst_valid, o_fault, o_fault_pc, o_mem_addr} !== {1'b0, 1'b1, target, target >> 2}) begin
                errors++;
                $display("FAIL bad_redirect %h [%0d]: got v=%b f=%b fpc=%h addr=%h, required v=0 f=1 fpc=%h",
                         target, c, o_inst_valid, o_fault, o_fault_pc, o_mem_addr, target);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        repeat (3) tick();
        checks++;
        if ({o_inst_valid, o_pc} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL async_pre: got v=%b pc=%h, required v=1 pc=0", o_inst_valid, o_pc);
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_inst_valid, o_pc, o_inst, o_mem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b pc=%h inst=%h addr=%h, required v=0 all zero",
                     o_inst_valid, o_pc, o_inst, o_mem_addr);
        end
        i_inst_ready = 1'b1;
        #4 i_rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({o_inst_valid, o_pc, o_inst} !== {1'b1, 32'(c * 4), exp_inst(32'(c * 4))}) begin
                errors++;
                $display("FAIL async_restart[%0d]: got v=%b pc=%h inst=%h, required v=1 pc=%h",
                         c, o_inst_valid, o_pc, o_inst, 32'(c * 4));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] = exp_inst(32'(i * 4));
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_fault_range();
        test_bad_redirect(32'h0000_0006);
        test_bad_redirect(32'(4 * MEM_WORDS));
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
